// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only register bank: synchronizes the SPI pins into clk,
// deserializes 16-bit frames and commits valid writes when chip-select rises.
module spi_reg_bank #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       copi_in,
    input  logic       ncs_in,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr
);

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned FRAME_W = 16;
    localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
    localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] vld_sync;
    logic                   sclk_prev;
    logic                   ncs_prev;
    logic                   ncs_live;

    logic [1:0]         state, state_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]   bit_cnt, cnt_next;

    logic sclk_s_c, copi_s_c, ncs_s_c;
    logic sclk_rise_c, ncs_rise_c, ncs_fall_c;
    logic do_write_c;

    assign sclk_s_c    = sclk_sync[SYNC_STAGES-1];
    assign copi_s_c    = copi_sync[SYNC_STAGES-1];
    assign ncs_s_c     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s_c & ~sclk_prev;
    assign ncs_rise_c  = ncs_s_c & ~ncs_prev;
    // A fall only counts once a genuine high has been seen since reset, so a
    // frame already in progress when reset releases is never picked up.
    assign ncs_fall_c  = ncs_live & ncs_prev & ~ncs_s_c;

    // Next-state, deserializer and commit decision
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        do_write_c = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall_c) begin
                    shift_next = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise_c) begin
                    state_next = COMMIT;
                end else if (sclk_rise_c) begin
                    shift_next = {shift_reg[FRAME_W-2:0], copi_s_c};
                    if (bit_cnt < CNT_SAT) begin
                        cnt_next = bit_cnt + 5'd1;
                    end
                end
            end
            COMMIT: begin
                do_write_c = (bit_cnt == CNT_FULL) && shift_reg[15]
                             && (shift_reg[14:8] <= 7'(MAX_ADDR));
                if (ncs_fall_c) begin
                    shift_next = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync       <= '0;
            copi_sync       <= '0;
            ncs_sync        <= '1;
            vld_sync        <= '0;
            sclk_prev       <= 1'b0;
            ncs_prev        <= 1'b1;
            ncs_live        <= 1'b0;
            state           <= IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
            wr_addr         <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s_c;
            ncs_prev  <= ncs_s_c;
            ncs_live  <= ncs_live | (vld_sync[SYNC_STAGES-1] & ncs_s_c);
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= cnt_next;
            wr_strobe <= do_write_c;
            if (do_write_c) begin
                wr_addr <= shift_reg[14:8];
                case (shift_reg[14:8])
                    7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
                    7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
                    7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
                    7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
                    7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
